axis_in_gather: RTL and testbench
=================================

Name: axis_in_gather

Overview:
- Column deserializer for the AXI-Stream path into the PE array; the inverse of the output column shifter.
- Accepts one ROWS-wide column per beat and packs COLS consecutive beats into one COLS×ROWS parallel word.
- The first accepted beat lands in column COLS-1 and is the first column the output shifter would emit.
- A short group terminated by s_last is zero-padded and flagged via m_keep.

Parameters:
ROWS, 8, words per column (one beat)
COLS, 24, columns per packed output word
WORD_WIDTH, 8, bits per word
TUSER_WIDTH, 8, sideband width, captured from the first beat of a group

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous, active-high reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat ready
s_last  in  1  last beat of the packet; closes the current group
s_user  in  TUSER_WIDTH  sideband; sampled on the first beat of a group only
s_data  in  ROWS*WORD_WIDTH  one column ([ROWS-1:0][WORD_WIDTH-1:0])
m_valid  out  1  packed word valid
m_ready  in  1  packed word ready
m_data  out  COLS*ROWS*WORD_WIDTH  packed word ([COLS-1:0][ROWS-1:0][WORD_WIDTH-1:0])
m_keep  out  COLS  bit c = 1 iff column c holds a real beat
m_user  out  TUSER_WIDTH  s_user of the group's first beat
m_last  out  1  group was closed by s_last

Behaviour:
- Transfers: input on s_valid&&s_ready; output on m_valid&&m_ready.
- Group counter cnt, width $clog2(COLS+1), counts 0..COLS-1.
- Reset (areset=1 at a rising edge):
  - state=FILL, cnt=0, s_ready=1, m_valid=0.
  - m_data=0, m_keep=0, m_user=0, m_last=0.
  - Reset mid-group discards the partial group; reset while m_valid=1 drops the pending word.
- FILL state (s_ready=1, m_valid=0), on each input transfer:
  - data[COLS-1-cnt] <= s_data; keep[COLS-1-cnt] <= 1.
  - If cnt==0: user <= s_user; all other columns and keep bits are cleared in the same edge.
  - If cnt==COLS-1 or s_last: go to OUT, s_ready <= 0, m_valid <= 1, m_last <= s_last, cnt <= 0.
  - Otherwise cnt <= cnt+1.
- OUT state (m_valid=1, s_ready=0): hold all outputs stable. On m_ready, go to FILL with s_ready <= 1 and m_valid <= 0.
- Latency and throughput (non-DBUF): m_valid rises the cycle after the closing beat is accepted. Best case is COLS+1 cycles per group (one bubble).
- Boundary cases:
  - s_last on the COLS-th beat gives a full group with m_last=1 and m_keep all ones.
  - s_last on beat k<COLS gives m_keep = ones in the top k bits; the lower COLS-k columns are 0.
  - s_last on the first beat gives a single-column word with m_keep = 1<<(COLS-1).
  - s_valid is ignored in OUT. m_ready is ignored while m_valid=0.
  - No data, keep, user or last bit survives into the next group.

Optional Feature:
- Macro: AXIS_IN_GATHER_DBUF_EN.
- Defined: separate fill and output registers.
  - On group completion, fill→output copy happens in the same edge if the output is empty or m_ready=1 that cycle. The fill side restarts at cnt=0 with no bubble.
  - If the output is held, s_ready stays 0 until it drains; the copy happens in the edge where m_ready=1.
  - Sustained rate: one beat per cycle, one word per COLS cycles.
  - Reset clears both buffers.
- Undefined: single buffer; FILL/OUT behaviour exactly as above.

Decomposition:
- Shared package: state enum {FILL, OUT}; typedefs col_t = logic [ROWS-1:0][WORD_WIDTH-1:0] and word_t = col_t [COLS-1:0]; localparam CNT_W = $clog2(COLS+1).
- The top-level parameters come from the common params header.
- One natural sub-module, axis_in_gather_buf: column write-enable decode plus keep/user capture. The top level keeps the counter, FSM and handshake; under DBUF it instantiates the buffer twice.

Test Plan (bench at COLS=4, ROWS=2, WORD_WIDTH=8):
- Reset then 4 beats 0x0101,0x0202,0x0303,0x0404, s_last=0, m_ready=1 → m_data col3..col0 = 0x0101,0x0202,0x0303,0x0404; m_keep=4'b1111; m_last=0; m_valid one cycle after beat 4.
- 2 beats 0xAAAA,0xBBBB with s_last on beat 2 → col3=0xAAAA, col2=0xBBBB, col1=col0=0; m_keep=4'b1100; m_last=1.
- A single beat with s_last, preceded by a full group of nonzero data → m_keep=4'b1000; columns 2..0 are 0 (no residue).
- m_ready held 0 for 5 cycles in OUT → s_ready=0 and m_data, m_user stable throughout. Then m_ready=1 → m_valid=0 and s_ready=1 on the next cycle. s_user=0x5A on beat 1 and 0xFF on beat 2 → m_user=0x5A.
- areset pulsed after 2 of 4 beats → all outputs 0 next cycle. The following 4-beat group is emitted correctly.
- DBUF defined, continuous s_valid=1 and m_ready=1 for 16 beats → s_ready constantly 1 and 4 words emitted. DBUF undefined → one s_ready=0 bubble per word.

Source files
------------

// File: rtl/axis_in_gather_pkg.sv
// rtl/axis_in_gather_pkg.sv - shared defaults, state encoding and column/word types for axis_in_gather
package axis_in_gather_pkg;

  localparam int DEF_ROWS        = 8;
  localparam int DEF_COLS        = 24;
  localparam int DEF_WORD_WIDTH  = 8;
  localparam int DEF_TUSER_WIDTH = 8;
  localparam int CNT_W           = $clog2(DEF_COLS + 1);

  typedef enum logic {FILL, OUT} state_t;

  typedef logic [DEF_ROWS-1:0][DEF_WORD_WIDTH-1:0] col_t;
  typedef col_t [DEF_COLS-1:0]                     word_t;

endpackage

// File: rtl/axis_in_gather_buf.sv
// rtl/axis_in_gather_buf.sv - packed-word register with column write decode, keep and user capture
// A whole-word load (ld_en) may coincide with a column write; the column write is applied on top.
module axis_in_gather_buf
  import axis_in_gather_pkg::*;
#(
  parameter  int ROWS        = DEF_ROWS,
  parameter  int COLS        = DEF_COLS,
  parameter  int WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter  int TUSER_WIDTH = DEF_TUSER_WIDTH,
  localparam int CW          = $clog2(COLS + 1),
  localparam int RW          = ROWS * WORD_WIDTH,
  localparam int DW          = COLS * RW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [CW-1:0]          cnt,
  input  logic [RW-1:0]          col_data,
  input  logic [TUSER_WIDTH-1:0] user_in,
  input  logic                   ld_en,
  input  logic [DW-1:0]          ld_data,
  input  logic [COLS-1:0]        ld_keep,
  input  logic [TUSER_WIDTH-1:0] ld_user,
  output logic [DW-1:0]          data,
  output logic [COLS-1:0]        keep,
  output logic [TUSER_WIDTH-1:0] user
);

  logic [DW-1:0]          data_q, data_d;
  logic [COLS-1:0]        keep_q, keep_d;
  logic [TUSER_WIDTH-1:0] user_q, user_d;

  always_comb begin
    data_d = data_q;
    keep_d = keep_q;
    user_d = user_q;
    if (ld_en) begin
      data_d = ld_data;
      keep_d = ld_keep;
      user_d = ld_user;
    end
    if (wr_en) begin
      // First beat of a group wipes every column so nothing leaks from the previous group.
      if (cnt == '0) begin
        data_d = '0;
        keep_d = '0;
        user_d = user_in;
      end
      for (int c = 0; c < COLS; c++) begin
        if (c == COLS - 1 - int'(cnt)) begin
          data_d[c*RW +: RW] = col_data;
          keep_d[c]          = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      keep_q <= '0;
      user_q <= '0;
    end else begin
      data_q <= data_d;
      keep_q <= keep_d;
      user_q <= user_d;
    end
  end

  assign data = data_q;
  assign keep = keep_q;
  assign user = user_q;

endmodule

// File: rtl/axis_in_gather.sv
// rtl/axis_in_gather.sv - AXI-Stream column deserializer packing COLS beats into one word
// AXIS_IN_GATHER_DBUF_EN selects separate fill/output buffers for bubble-free streaming.
module axis_in_gather
  import axis_in_gather_pkg::*;
#(
  parameter int ROWS        = DEF_ROWS,
  parameter int COLS        = DEF_COLS,
  parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int TUSER_WIDTH = DEF_TUSER_WIDTH
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic                              s_last,
  input  logic [TUSER_WIDTH-1:0]            s_user,
  input  logic [ROWS*WORD_WIDTH-1:0]        s_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [COLS*ROWS*WORD_WIDTH-1:0]   m_data,
  output logic [COLS-1:0]                   m_keep,
  output logic [TUSER_WIDTH-1:0]            m_user,
  output logic                              m_last
);

  localparam int             CW      = $clog2(COLS + 1);
  localparam int             DW      = COLS * ROWS * WORD_WIDTH;
  localparam logic [CW-1:0]  CNT_MAX = CW'(COLS - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc, close;

  assign s_ready = (state_q == FILL);
  assign acc     = s_valid && s_ready;
  assign close   = acc && ((cnt_q == CNT_MAX) || s_last);

  always_comb begin
    cnt_d = cnt_q;
    if (close)    cnt_d = '0;
    else if (acc) cnt_d = cnt_q + CW'(1);
  end

`ifndef AXIS_IN_GATHER_DBUF_EN
  logic last_q, last_d;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      FILL: if (close) begin
        state_d = OUT;
        last_d  = s_last;
      end
      OUT:  if (m_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  axis_in_gather_buf #(
    .ROWS(ROWS), .COLS(COLS), .WORD_WIDTH(WORD_WIDTH), .TUSER_WIDTH(TUSER_WIDTH)
  ) u_buf (
    .clk(aclk), .rst(areset), .wr_en(acc), .cnt(cnt_q), .col_data(s_data), .user_in(s_user),
    .ld_en(1'b0), .ld_data({DW{1'b0}}), .ld_keep({COLS{1'b0}}), .ld_user({TUSER_WIDTH{1'b0}}),
    .data(m_data), .keep(m_keep), .user(m_user)
  );

  assign m_valid = (state_q == OUT);
  assign m_last  = last_q;
`else
  // state_q == OUT here means a completed fill word is waiting for the output buffer.
  logic                   ov_q, ov_d, fl_q, fl_d, ol_q, ol_d;
  logic                   copy, o_wr;
  logic [DW-1:0]          f_data;
  logic [COLS-1:0]        f_keep;
  logic [TUSER_WIDTH-1:0] f_user;

  always_comb begin
    state_d = state_q;
    ov_d    = ov_q;
    fl_d    = fl_q;
    ol_d    = ol_q;
    copy    = 1'b0;
    o_wr    = 1'b0;
    if (ov_q && m_ready) ov_d = 1'b0;
    case (state_q)
      FILL: if (close) begin
        if (!ov_q || m_ready) begin
          copy = 1'b1;
          o_wr = 1'b1;
          ov_d = 1'b1;
          ol_d = s_last;
        end else begin
          state_d = OUT;
          fl_d    = s_last;
        end
      end
      OUT: if (m_ready) begin
        copy    = 1'b1;
        ov_d    = 1'b1;
        ol_d    = fl_q;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      fl_q    <= 1'b0;
      ol_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      fl_q    <= fl_d;
      ol_q    <= ol_d;
    end
  end

  axis_in_gather_buf #(
    .ROWS(ROWS), .COLS(COLS), .WORD_WIDTH(WORD_WIDTH), .TUSER_WIDTH(TUSER_WIDTH)
  ) u_fill (
    .clk(aclk), .rst(areset), .wr_en(acc), .cnt(cnt_q), .col_data(s_data), .user_in(s_user),
    .ld_en(1'b0), .ld_data({DW{1'b0}}), .ld_keep({COLS{1'b0}}), .ld_user({TUSER_WIDTH{1'b0}}),
    .data(f_data), .keep(f_keep), .user(f_user)
  );

  axis_in_gather_buf #(
    .ROWS(ROWS), .COLS(COLS), .WORD_WIDTH(WORD_WIDTH), .TUSER_WIDTH(TUSER_WIDTH)
  ) u_out (
    .clk(aclk), .rst(areset), .wr_en(o_wr), .cnt(cnt_q), .col_data(s_data), .user_in(s_user),
    .ld_en(copy), .ld_data(f_data), .ld_keep(f_keep), .ld_user(f_user),
    .data(m_data), .keep(m_keep), .user(m_user)
  );

  assign m_valid = ov_q;
  assign m_last  = ol_q;
`endif

endmodule

// File: tb/tb_axis_in_gather.sv
// tb/tb_axis_in_gather.sv - scoreboard bench for axis_in_gather at COLS=4, ROWS=2, WORD_WIDTH=8
module tb_axis_in_gather;

  logic        aclk = 1'b0;
  logic        areset, s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic [7:0]  s_user, m_user;
  logic [15:0] s_data;
  logic [63:0] m_data;
  logic [3:0]  m_keep;

  axis_in_gather #(.ROWS(2), .COLS(4), .WORD_WIDTH(8), .TUSER_WIDTH(8)) dut (
    .aclk(aclk), .areset(areset), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_user(s_user), .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep), .m_user(m_user), .m_last(m_last)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  k;
    logic [7:0]  u;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0, pops = 0, stalls = 0;
  logic count_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] w4(input logic [15:0] c3, c2, c1, c0);
    return {c3, c2, c1, c0};
  endfunction

  task automatic push(input logic [63:0] d, input logic [3:0] k, input logic [7:0] u, input logic l);
    exp_t e;
    e.d = d; e.k = k; e.u = u; e.l = l;
    q.push_back(e);
  endtask

  // Presents one beat and returns one step after the edge that accepted it, s_valid still high.
  task automatic beat(input logic [15:0] d, input logic [7:0] u, input logic l);
    int n;
    s_valid = 1'b1; s_data = d; s_user = u; s_last = l;
    n = 0;
    while (!s_ready && n < 64) begin
      @(negedge aclk);
      n++;
    end
    if (!s_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_timeout: s_ready stuck at %0b, required 1", s_ready);
    end
    @(posedge aclk); #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0; s_last = 1'b0;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Monitor: every output handshake is checked against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_word: got %0h, required no word", m_data);
        end else begin
          e = q.pop_front();
          chk("m_data", m_data, e.d);
          chk("m_keep", 64'(m_keep), 64'(e.k));
          chk("m_user", 64'(m_user), 64'(e.u));
          chk("m_last", 64'(m_last), 64'(e.l));
          pops++;
        end
      end
    end
  end

  always @(negedge aclk) if (count_en && s_valid && !s_ready) stalls++;

  initial begin
    logic [63:0] d0;
    logic [7:0]  u0;
    int          p0, exp_stalls;

    areset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_user = '0; s_data = '0; m_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data",  m_data, 64'd0);
    chk("rst_m_keep",  64'(m_keep), 64'd0);
    chk("rst_m_user",  64'(m_user), 64'd0);
    chk("rst_m_last",  64'(m_last), 64'd0);
    areset = 1'b0;

    // Full group, first beat lands in column 3.
    push(w4(16'h0101, 16'h0202, 16'h0303, 16'h0404), 4'b1111, 8'h11, 1'b0);
    beat(16'h0101, 8'h11, 1'b0);
    beat(16'h0202, 8'h22, 1'b0);
    beat(16'h0303, 8'h33, 1'b0);
    beat(16'h0404, 8'h44, 1'b0);
    chk("latency_m_valid", 64'(m_valid), 64'd1);
    idle(3);

    // Short group closed by s_last on beat 2.
    push(w4(16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000), 4'b1100, 8'h21, 1'b1);
    beat(16'hAAAA, 8'h21, 1'b0);
    beat(16'hBBBB, 8'h22, 1'b1);
    idle(3);

    // Full nonzero group then a single-beat group: no residue allowed.
    push(w4(16'h1111, 16'h2222, 16'h3333, 16'h4444), 4'b1111, 8'h31, 1'b0);
    push(w4(16'h7777, 16'h0000, 16'h0000, 16'h0000), 4'b1000, 8'h41, 1'b1);
    beat(16'h1111, 8'h31, 1'b0);
    beat(16'h2222, 8'h32, 1'b0);
    beat(16'h3333, 8'h33, 1'b0);
    beat(16'h4444, 8'h34, 1'b0);
    idle(3);
    beat(16'h7777, 8'h41, 1'b1);
    idle(3);

    // Output back-pressure: word must hold, user comes from the first beat.
    m_ready = 1'b0;
    push(w4(16'hC1C1, 16'hC2C2, 16'h0000, 16'h0000), 4'b1100, 8'h5A, 1'b1);
    beat(16'hC1C1, 8'h5A, 1'b0);
    beat(16'hC2C2, 8'hFF, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    chk("hold_m_valid_rise", 64'(m_valid), 64'd1);
    d0 = m_data; u0 = m_user;
    repeat (5) begin
      @(negedge aclk);
`ifdef AXIS_IN_GATHER_DBUF_EN
      chk("hold_s_ready", 64'(s_ready), 64'd1);
`else
      chk("hold_s_ready", 64'(s_ready), 64'd0);
`endif
      chk("hold_m_valid", 64'(m_valid), 64'd1);
      chk("hold_m_data", m_data, d0);
      chk("hold_m_user", 64'(m_user), 64'(u0));
    end
    @(posedge aclk); #1;
    m_ready = 1'b1;
    @(posedge aclk); #1;
    chk("release_m_valid", 64'(m_valid), 64'd0);
    chk("release_s_ready", 64'(s_ready), 64'd1);
    idle(2);

    // Reset in the middle of a group discards it.
    beat(16'hE1E1, 8'h61, 1'b0);
    beat(16'hE2E2, 8'h62, 1'b0);
    s_valid = 1'b0;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd1);
    chk("midrst_m_data", m_data, 64'd0);
    chk("midrst_m_keep", 64'(m_keep), 64'd0);
    chk("midrst_m_user", 64'(m_user), 64'd0);
    chk("midrst_m_last", 64'(m_last), 64'd0);
    push(w4(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D), 4'b1111, 8'h71, 1'b0);
    beat(16'h0A0A, 8'h71, 1'b0);
    beat(16'h0B0B, 8'h72, 1'b0);
    beat(16'h0C0C, 8'h73, 1'b0);
    beat(16'h0D0D, 8'h74, 1'b0);
    idle(3);

    // Continuous streaming: 16 beats, 4 words.
    p0 = pops; stalls = 0;
    for (int g = 0; g < 4; g++)
      push(w4({8'h10 + 8'(g), 8'h01}, {8'h10 + 8'(g), 8'h02}, {8'h10 + 8'(g), 8'h03},
              {8'h10 + 8'(g), 8'h04}), 4'b1111, 8'h80 + 8'(g), 1'b0);
    count_en = 1'b1;
    for (int g = 0; g < 4; g++)
      for (int b = 0; b < 4; b++)
        beat({8'h10 + 8'(g), 8'(b + 1)}, (b == 0) ? 8'h80 + 8'(g) : 8'hEE, 1'b0);
    s_valid = 1'b0;
    count_en = 1'b0;
`ifdef AXIS_IN_GATHER_DBUF_EN
    exp_stalls = 0;
`else
    exp_stalls = 3;
`endif
    chk("stream_stalls", 64'(stalls), 64'(exp_stalls));
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge aclk);
    #1;
    chk("drain_queue", 64'(q.size()), 64'd0);
    chk("stream_words", 64'(pops - p0), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
